// File: rtl/pipe_ifid.sv
// IF/ID pipeline register with load-use hazard stall, branch flush squash,
// and saturating stall/flush event counters.
module pipe_ifid #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [15:0]      instr_i,
  input  logic [15:0]      PCadder1_sum_i,
  input  logic             flush_i,
  input  logic             IDEX_memRead_i,
  input  logic [2:0]       IDEX_wrAddr_i,
  output logic [15:0]      instr_o,
  output logic [15:0]      PCadder1_sum_o,
  output logic             valid_o,
  output logic             PC_write_o,
  output logic             bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 16;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Zero initialisers give a defined state at time zero before the first reset edge.
  state_t             state_q     = RUN;
  logic [INSTR_W-1:0] instr_q     = '0;
  logic [PC_W-1:0]    pc_q        = '0;
  logic               valid_q     = 1'b0;
  logic [CNT_W-1:0]   stall_cnt_q = '0;
  logic [CNT_W-1:0]   flush_cnt_q = '0;

  state_t             state_d;
  logic [INSTR_W-1:0] instr_d;
  logic [PC_W-1:0]    pc_d;
  logic               valid_d;
  logic [CNT_W-1:0]   stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_d;
  logic               hazard;

  // Load-use hazard: decode source fields match a pending load destination.
  assign hazard = valid_q & IDEX_memRead_i &
                  ((IDEX_wrAddr_i == instr_q[12:10]) | (IDEX_wrAddr_i == instr_q[9:7])) &
                  ~flush_i;

  assign PC_write_o     = ~hazard;
  assign bubble_o       = hazard | flush_i | ~valid_q;
  assign instr_o        = instr_q;
  assign PCadder1_sum_o = pc_q;
  assign valid_o        = valid_q;
  assign stall_cnt_o    = stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;

  // Next-state: flush beats hazard beats normal load; HOLD re-evaluates like RUN.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_i) begin
      state_d = RUN;
      instr_d = '0;
      pc_d    = '0;
      valid_d = 1'b0;
      if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (hazard) begin
      state_d = HOLD;
      if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      state_d = RUN;
      instr_d = instr_i;
      pc_d    = PCadder1_sum_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q     <= RUN;
      instr_q     <= '0;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
